// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Package  : cache_pkg                                           |
// | Brief    : shared widths, arbiter state encoding and helpers   |
// |            for the cache port arbiter                          |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
package cache_pkg;

  // Default physical address and data word widths
  localparam int PA_WIDTH  = 32;
  localparam int WRD_WIDTH = 32;

  // WAIT cycle counter width; large enough for TIMEOUT up to 255
  localparam int CNT_WIDTH = 8;

  // Arbiter transaction states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Convert a requester id into its one-hot port mask
  function automatic logic [1:0] id2oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : rr_pick2                                            |
// | Brief    : two-way round-robin winner picker (combinational)   |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic       valid_o,
  output logic       win_id_o
);

  // A lone requester always wins; on a tie the round-robin pointer decides
  always_comb begin
    valid_o  = |req_i;
    win_id_o = (&req_i) ? rr_i : req_i[1];
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : cache_port_arbiter                                  |
// | Brief    : arbitrates two load/store requesters onto a single  |
// |            cache port, one transaction at a time, with a WAIT  |
// |            timeout and a sticky error flag                     |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
module cache_port_arbiter #(
  parameter int PA_WIDTH  = cache_pkg::PA_WIDTH,
  parameter int WRD_WIDTH = cache_pkg::WRD_WIDTH,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [PA_WIDTH-1:0]  addr0,
  input  logic [PA_WIDTH-1:0]  addr1,
  input  logic [WRD_WIDTH-1:0] wdata0,
  input  logic [WRD_WIDTH-1:0] wdata1,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [WRD_WIDTH-1:0] rdata,
  output logic                 err,
  output logic                 c_rd_en,
  output logic                 c_wr_en,
  output logic [PA_WIDTH-1:0]  c_addr,
  output logic [WRD_WIDTH-1:0] c_wdata,
  input  logic                 c_ack,
  input  logic [WRD_WIDTH-1:0] c_rdata
);

  import cache_pkg::*;

  // Last WAIT count value before the transaction is abandoned
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   we_q, we_d;
  logic [PA_WIDTH-1:0]    addr_q, addr_d;
  logic [WRD_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   rr_q, rr_d;
  logic [WRD_WIDTH-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic                   w_pick_valid;
  logic                   w_pick_id;

  rr_pick2 u_rr_pick2 (
    .req_i    (req),
    .rr_i     (rr_q),
    .valid_o  (w_pick_valid),
    .win_id_o (w_pick_id)
  );

  // State and transaction context registers; reset aborts any transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: latch the winner in IDLE, count WAIT cycles, finish on ack or timeout
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_pick_valid) begin
          state_d = ST_ISSUE;
          owner_d = w_pick_id;
          we_d    = w_pick_id ? we[1]  : we[0];
          addr_d  = w_pick_id ? addr1  : addr0;
          wdata_d = w_pick_id ? wdata1 : wdata0;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end

      ST_WAIT: begin
        if (c_ack) begin
          state_d = ST_RESP;
          rdata_d = we_q ? '0 : c_rdata;
          rr_d    = ~owner_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          rr_d    = ~owner_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake pulses and cache strobes decode directly from the registered state
  always_comb begin
    gnt     = (state_q == ST_ISSUE) ? id2oh(owner_q) : 2'b00;
    done    = (state_q == ST_RESP)  ? id2oh(owner_q) : 2'b00;
    c_rd_en = (state_q == ST_ISSUE) & ~we_q;
    c_wr_en = (state_q == ST_ISSUE) &  we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    rdata   = rdata_q;
    err     = err_q;
  end

endmodule : cache_port_arbiter
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | Module   : tb_cache_port_arbiter                               |
// | Brief    : scoreboard bench for cache_port_arbiter             |
// | Revision : 1.0                                                 |
// +----------------------------------------------------------------+
module tb_cache_port_arbiter;

  localparam int PAW = 32;
  localparam int DW  = 32;
  localparam int TO  = 4;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req;
  logic [1:0]     we;
  logic [PAW-1:0] addr0, addr1;
  logic [DW-1:0]  wdata0, wdata1;
  logic [1:0]     gnt;
  logic [1:0]     done;
  logic [DW-1:0]  rdata;
  logic           err;
  logic           c_rd_en, c_wr_en;
  logic [PAW-1:0] c_addr;
  logic [DW-1:0]  c_wdata;
  logic           c_ack;
  logic [DW-1:0]  c_rdata;

  cache_port_arbiter #(
    .PA_WIDTH  (PAW),
    .WRD_WIDTH (DW),
    .TIMEOUT   (TO)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .c_rd_en (c_rd_en),
    .c_wr_en (c_wr_en),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_ack   (c_ack),
    .c_rdata (c_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]    done;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  logic exp_err = 1'b0;

  // Scoreboard: every completion pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (done !== 2'b00) begin
      if (sb_q.size() == 0) begin
        check_val("done_unexpected", {62'd0, done}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("sb_done",  {62'd0, done}, {62'd0, e.done});
        check_val("sb_rdata", {32'd0, rdata}, {32'd0, e.rdata});
        check_val("sb_err",   {63'd0, err},   {63'd0, e.err});
      end
    end
  end

  task automatic check_quiet(input string tag);
    check_val({tag, "_gnt"},   {62'd0, gnt},   64'd0);
    check_val({tag, "_done"},  {62'd0, done},  64'd0);
    check_val({tag, "_err"},   {63'd0, err},   64'd0);
    check_val({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
    check_val({tag, "_strb"},  {62'd0, c_rd_en, c_wr_en}, 64'd0);
    check_val({tag, "_caddr"}, {32'd0, c_addr},  64'd0);
    check_val({tag, "_cwdat"}, {32'd0, c_wdata}, 64'd0);
  endtask

  // One complete transaction, called at a negedge while the DUT is IDLE.
  // ack_wait: WAIT cycle index carrying c_ack (0 = first), negative = never.
  task automatic run_txn(input string tag, input logic [1:0] rq, input logic [1:0] wm,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int ack_wait, input logic [31:0] ack_data,
                         input logic spur, input logic exp_id, output int gnt_cyc);
    exp_t        e;
    logic        e_we;
    logic [31:0] e_a, e_d;
    int          n_wait;
    e_we = exp_id ? wm[1] : wm[0];
    e_a  = exp_id ? a1 : a0;
    e_d  = exp_id ? d1 : d0;
    if (ack_wait < 0) exp_err = 1'b1;
    e.done  = exp_id ? 2'b10 : 2'b01;
    e.rdata = (ack_wait < 0 || e_we) ? 32'd0 : ack_data;
    e.err   = exp_err;
    sb_q.push_back(e);

    req = rq; we = wm; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    if (spur) begin
      c_ack = 1'b1;
      c_rdata = 32'hBAD0_0BAD;
    end

    @(negedge clk);  // ISSUE
    gnt_cyc = cyc;
    c_ack = 1'b0;
    check_val({tag, "_gnt"},   {62'd0, gnt}, {62'd0, e.done});
    check_val({tag, "_rd_en"}, {63'd0, c_rd_en}, {63'd0, ~e_we});
    check_val({tag, "_wr_en"}, {63'd0, c_wr_en}, {63'd0, e_we});
    check_val({tag, "_caddr"}, {32'd0, c_addr},  {32'd0, e_a});
    check_val({tag, "_cwdat"}, {32'd0, c_wdata}, {32'd0, e_d});
    if (rq != 2'b11) req = 2'b00;
    addr0 = ~a0; addr1 = ~a1; wdata0 = ~d0; wdata1 = ~d1;

    n_wait = (ack_wait < 0) ? TO : ack_wait + 1;
    for (int k = 0; k < n_wait; k++) begin
      @(negedge clk);  // WAIT cycle k
      check_val({tag, "_wait_strb"}, {62'd0, c_rd_en, c_wr_en, gnt, done}, 64'd0);
      check_val({tag, "_wait_caddr"}, {c_wdata, c_addr}, {e_d, e_a});
      if (ack_wait >= 0 && k == ack_wait) begin
        c_ack = 1'b1;
        c_rdata = ack_data;
      end
    end

    @(negedge clk);  // RESP
    c_ack = 1'b0;
    c_rdata = 32'h0;
    check_val({tag, "_done_cyc"}, {62'd0, done}, {62'd0, e.done});

    @(negedge clk);  // back in IDLE
    check_val({tag, "_idle_done"}, {62'd0, done}, 64'd0);
    check_val({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g_prev;
    logic [1:0] cont_ids [4];

    rst_n = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    c_ack = 1'b0; c_rdata = '0;

    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Load from requester 0, ack in first WAIT cycle
    run_txn("load", 2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0,
            0, 32'hDEADBEEF, 1'b0, 1'b0, g);

    // Store from requester 1, ack in third WAIT cycle; load data must be ignored
    run_txn("store", 2'b10, 2'b10, 32'h0, 32'h2C, 32'h0, 32'h55,
            2, 32'h1234_5678, 1'b0, 1'b1, g);

    // Contention with both requests held: alternate 0,1,0,1 every 4 cycles
    cont_ids[0] = 1'b0; cont_ids[1] = 1'b1; cont_ids[2] = 1'b0; cont_ids[3] = 1'b1;
    g_prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_txn("contend", 2'b11, 2'b00, 32'h40, 32'h80, 32'h0, 32'h0,
              0, 32'hC0DE_0000 + 32'(i), 1'b0, cont_ids[i][0], g);
      if (g_prev >= 0) check_val("contend_gap", 64'(g - g_prev), 64'd4);
      g_prev = g;
    end
    req = 2'b00;

    // Ack arriving in the last WAIT cycle still wins over timeout
    run_txn("ack_last", 2'b01, 2'b00, 32'h1F0, 32'h0, 32'h0, 32'h0,
            TO - 1, 32'h7777_8888, 1'b0, 1'b0, g);

    // Spurious ack while IDLE with no request: nothing may happen
    c_ack = 1'b1; c_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("spur_idle", {62'd0, gnt, done}, 64'd0);
    end
    c_ack = 1'b0;

    // Spurious ack during IDLE->ISSUE must not complete the transaction early
    run_txn("spur_issue", 2'b10, 2'b00, 32'h0, 32'h88, 32'h0, 32'h0,
            1, 32'hCAFE_F00D, 1'b1, 1'b1, g);

    // Timeout: ack never arrives
    run_txn("timeout", 2'b10, 2'b00, 32'h0, 32'h300, 32'h0, 32'h0,
            -1, 32'h0, 1'b0, 1'b1, g);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("err_sticky", {63'd0, err}, 64'd1);
    end

    // Normal load after timeout leaves rr pointing at requester 1
    run_txn("post_to", 2'b01, 2'b00, 32'h44, 32'h0, 32'h0, 32'h0,
            0, 32'hA5A5_A5A5, 1'b0, 1'b0, g);

    // Reset in the middle of WAIT
    req = 2'b10; we = 2'b00; addr1 = 32'h3C; wdata1 = 32'h99;
    @(negedge clk);  // ISSUE
    req = 2'b00;
    @(negedge clk);  // WAIT
    #1 rst_n = 1'b0;
    #1 check_quiet("async_rst");
    @(negedge clk);
    check_quiet("rst_held");
    exp_err = 1'b0;
    rst_n = 1'b1;

    // First contention after reset must go to requester 0
    run_txn("after_rst", 2'b11, 2'b00, 32'h500, 32'h600, 32'h0, 32'h0,
            0, 32'h0F0F_0F0F, 1'b0, 1'b0, g);
    req = 2'b00;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cache_port_arbiter
`default_nettype wire

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter PA_WIDTH, default 32, physical address width.
REQ-002 Parameter WRD_WIDTH, default 32, data word width.
REQ-003 Parameter TIMEOUT, default 64, maximum WAIT cycles before abort; legal range 2..255.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port req  in  2  per-requester request; bit i belongs to requester i.
REQ-007 Port we  in  2  per-requester write select: 1 = store, 0 = load.
REQ-008 Port addr0, addr1  in  PA_WIDTH each  per-requester address.
REQ-009 Port wdata0, wdata1  in  WRD_WIDTH each  per-requester store data.
REQ-010 Port gnt  out  2  one-cycle accept pulse to the winner.
REQ-011 Port done  out  2  one-cycle completion pulse to the owner.
REQ-012 Port rdata  out  WRD_WIDTH  load result, valid while done is high.
REQ-013 Port err  out  1  sticky timeout flag.
REQ-014 Port c_rd_en, c_wr_en  out  1 each  cache read/write strobes.
REQ-015 Port c_addr  out  PA_WIDTH  cache address.
REQ-016 Port c_wdata  out  WRD_WIDTH  cache store data.
REQ-017 Port c_ack  in  1  cache completion pulse.
REQ-018 Port c_rdata  in  WRD_WIDTH  cache load word, sampled when c_ack is high.

Function
REQ-019 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, and SHALL transition IDLE->ISSUE on any req, ISSUE->WAIT unconditionally, WAIT->RESP on c_ack or timeout, and RESP->IDLE unconditionally.
REQ-020 In IDLE with any req bit high, the block SHALL choose a winner and latch that requester's id, we, addr and wdata.
- Only one bit high: that requester wins.
- Both bits high: the requester named by the round-robin pointer rr wins.
REQ-021 gnt[winner] SHALL be high only during ISSUE, for exactly one cycle.
REQ-022 During ISSUE the block SHALL drive the latched addr and wdata on c_addr and c_wdata, with c_rd_en = ~we and c_wr_en = we, for exactly one cycle.
REQ-023 c_addr and c_wdata SHALL hold the latched values through WAIT; the strobes SHALL be 0 outside ISSUE.
REQ-024 c_ack SHALL be ignored in any state other than WAIT.
REQ-025 On c_ack in WAIT, rdata SHALL capture c_rdata for a load, or 0 for a store, and done[owner] SHALL be high for exactly one cycle in RESP.
REQ-026 Minimum transaction latency SHALL be 4 cycles (req sampled to RESP exit) when c_ack arrives in the first WAIT cycle.
REQ-027 A WAIT cycle counter SHALL count from 0. If it reaches TIMEOUT-1 without c_ack, the block SHALL enter RESP with done[owner]=1, rdata=0 and err set.
REQ-028 err SHALL stay set until reset.
REQ-029 On entry to RESP, rr SHALL point to the requester that did not own the transaction.
REQ-030 A requester SHALL deassert req in the cycle after gnt. req still high in IDLE after RESP SHALL be treated as a new request.
REQ-031 Changes on req, addr or wdata after latching SHALL NOT affect the transaction in flight.

Reset
REQ-032 While rst_n is low, the block SHALL hold the following values regardless of clk, aborting any transaction in flight:
- state = IDLE, rr = 0, counter = 0
- gnt = 0, done = 0, err = 0, rdata = 0
- c_rd_en = 0, c_wr_en = 0, c_addr = 0, c_wdata = 0
REQ-033 The first winner selection SHALL occur at the first rising clk edge after rst_n goes high.

Structure
REQ-034 The shared package cache_pkg SHALL hold PA_WIDTH, WRD_WIDTH and the arbiter state enumeration.
REQ-035 Round-robin winner selection SHALL be a sub-module rr_pick2, combinational, with inputs req[1:0] and rr and outputs valid and winner id.

Verification
REQ-036 Load: req=01, we=00, addr0=0x100; c_ack in the 1st WAIT cycle with c_rdata=0xDEADBEEF.
- Expect gnt=01 in cycle 1, c_rd_en=1 in cycle 1, done=01 in cycle 3, rdata=0xDEADBEEF.
REQ-037 Contention: req=11 held, rr=0, ack always immediate.
- Expect grant order 0,1,0,1 with gnt pulses 4 cycles apart.
REQ-038 Store: req=10, we=10, addr1=0x2C, wdata1=0x55; c_ack after 3 WAIT cycles.
- Expect c_wr_en=1 for exactly 1 cycle, c_wdata=0x55, done=10, rdata=0.
REQ-039 Timeout: TIMEOUT=4 and c_ack never asserted.
- Expect done pulse after 4 WAIT cycles, err=1 and held until reset.
REQ-040 Reset mid-WAIT: assert rst_n=0 asynchronously.
- Expect all outputs 0 immediately.
- Expect the next req=11 to grant requester 0.
REQ-041 Spurious c_ack during IDLE or ISSUE.
- Expect no done pulse and no state change.
